gin_feeder: RTL
===============

GIN_FEEDER -- requirements
Module: gin_feeder

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, giving the width of the data word.
REQ-002 SHALL have parameter TAG_LENGTH, default 4, giving the width of the multicast tag.
REQ-003 SHALL have parameter NUM_CONTROLLERS, default 10, giving the number of downstream multicast controllers.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, giving packet buffer entries; it SHALL be a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstb, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream packet is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the feeder can accept a packet.
REQ-009 SHALL have port in_tag, input, TAG_LENGTH bits: the packet's destination tag.
REQ-010 SHALL have port in_data, input, BITWIDTH bits: the packet's payload.
REQ-011 SHALL have port controller_ready, input, NUM_CONTROLLERS bits: per-controller ready flags from the bus.
REQ-012 SHALL have port controller_enable, output, 1 bit: the broadcast strobe to the bus.
REQ-013 SHALL have port tag, output, TAG_LENGTH bits: the tag presented to the bus.
REQ-014 SHALL have port data_source, output, BITWIDTH bits: the data presented to the bus.
REQ-015 SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or the state is not IDLE.
REQ-016 SHALL have port issued_count, output, 16 bits: the count of packets broadcast.

Function
REQ-017 SHALL buffer packets in a circular FIFO of FIFO_DEPTH entries {tag, data}; the read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-018 SHALL drive in_ready as !full (combinational from the count); a push SHALL occur on an edge where in_valid && in_ready.
REQ-019 SHALL not accept a push while full, even when a pop occurs on the same edge.
REQ-020 SHALL implement an FSM with states IDLE, WAIT, ISSUE, with transitions as follows:
- IDLE -> WAIT when count != 0.
- WAIT -> ISSUE when &controller_ready == 1.
- ISSUE -> WAIT if the count after the pop (and any simultaneous push) is != 0, else ISSUE -> IDLE.
REQ-021 SHALL hold WAIT indefinitely while any controller_ready bit is 0.
REQ-022 SHALL assert controller_enable = 1 for exactly one cycle while the state is ISSUE, and 0 otherwise.
REQ-023 SHALL drive tag and data_source from the FIFO head, registered, stable throughout WAIT and ISSUE.
REQ-024 SHALL hold the last values of tag and data_source in IDLE.
REQ-025 SHALL pop the head on the edge leaving ISSUE.
REQ-026 SHALL increment issued_count on that same edge, wrapping from 0xFFFF to 0.
REQ-027 SHALL, for a push at edge N into an empty FIFO with all controllers ready, assert controller_enable in the cycle following edge N+2.
REQ-028 SHALL sustain a throughput of one packet per 2 cycles.
REQ-029 SHALL support a simultaneous push and pop in ISSUE when not full: the count is unchanged and FIFO order is preserved.
REQ-030 SHALL issue packets strictly in arrival order, with no drop and no duplicate.

Reset
REQ-031 SHALL, while rstb = 1 at an edge, return the state to IDLE, set pointers and count to 0, clear issued_count, clear tag and data_source to 0, and clear controller_enable to 0.
REQ-032 SHALL have in_ready = 1 and busy = 0 after reset.
REQ-033 SHALL, when reset is asserted mid-WAIT or mid-ISSUE, discard all buffered packets, issue no strobe in the following cycle, and not retain FIFO contents.

Configuration
REQ-034 SHALL, with macro GIN_FEEDER_TIMEOUT_EN defined, add output timeout (1 bit) and an 8-bit WAIT-cycle counter that clears on entry to WAIT and saturates at 255.
REQ-035 SHALL, in that configuration, set timeout sticky-high when the counter reaches 255; only reset clears it, and FSM behaviour is otherwise unchanged.
REQ-036 SHALL, without GIN_FEEDER_TIMEOUT_EN, have no timeout port and no counter logic.

Verification
REQ-037 Single packet: push {tag=3, data=0x00A5} into an empty FIFO with controller_ready all ones -> controller_enable high exactly 1 cycle, 2 cycles after the accept; tag=3, data_source=0x00A5; issued_count=1.
REQ-038 Backpressure: controller_ready=10'h3FE for 20 cycles, then all ones -> state stays WAIT with enable 0 for 20 cycles; one strobe follows; data is stable throughout.
REQ-039 Full FIFO: push 5 packets back-to-back with ready held low -> in_ready=0 after the 4th push; the 5th is held upstream; after release, 5 strobes occur in order 1..5.
REQ-040 Streaming: 8 packets offered continuously with all ready -> strobes on alternate cycles; 8 strobes; issued_count=8; pointers wrap correctly.
REQ-041 Reset mid-WAIT: 2 packets buffered, ready low, rstb pulsed -> no strobe; busy=0; in_ready=1; issued_count=0.
REQ-042 With GIN_FEEDER_TIMEOUT_EN defined: ready held low for 300 cycles -> timeout rises at the 255th WAIT cycle and stays high after the packet issues.

Source files
------------

// File: rtl/gin_feeder.sv
// gin_feeder: tagged packet FIFO feeding a multicast bus; define GIN_FEEDER_TIMEOUT_EN for a sticky WAIT timeout flag
module gin_feeder #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_LENGTH-1:0]      in_tag,
    input  logic [BITWIDTH-1:0]        in_data,
    input  logic [NUM_CONTROLLERS-1:0] controller_ready,
    output logic                       controller_enable,
    output logic [TAG_LENGTH-1:0]      tag,
    output logic [BITWIDTH-1:0]        data_source,
    output logic                       busy,
    output logic [15:0]                issued_count
`ifdef GIN_FEEDER_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
    state_t state, state_nxt;
    logic [TAG_LENGTH-1:0] tag_mem [FIFO_DEPTH];
    logic [BITWIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_p1;
    logic [AW:0] count, count_nxt;
    logic push, pop, load;
    logic [TAG_LENGTH-1:0] load_tag;
    logic [BITWIDTH-1:0] load_data;
    assign in_ready = count != (AW+1)'(FIFO_DEPTH);
    assign push = in_valid && in_ready;
    assign pop = state == ISSUE;
    assign rd_ptr_p1 = rd_ptr + 1'b1;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    assign controller_enable = state == ISSUE;
    assign busy = count != '0 || state != IDLE;
    always_comb begin
        state_nxt = (state == IDLE) ? (count != '0 ? WAIT : IDLE)
                  : (state == WAIT) ? (&controller_ready ? ISSUE : WAIT)
                  : (count_nxt != '0 ? WAIT : IDLE);
        load = state_nxt == WAIT && state != WAIT;
        // leaving ISSUE the new head is the next entry, or the word being pushed right now
        load_tag = (state == IDLE) ? tag_mem[rd_ptr] : (count > (AW+1)'(1)) ? tag_mem[rd_ptr_p1] : in_tag;
        load_data = (state == IDLE) ? data_mem[rd_ptr] : (count > (AW+1)'(1)) ? data_mem[rd_ptr_p1] : in_data;
    end
    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            issued_count <= '0;
            tag <= '0;
            data_source <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr_p1;
                issued_count <= issued_count + 16'd1;
            end
            if (load) begin
                tag <= load_tag;
                data_source <= load_data;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= in_tag;
            data_mem[wr_ptr] <= in_data;
        end
    end
`ifdef GIN_FEEDER_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic timeout_q;
    assign timeout = timeout_q || wait_cnt == 8'hFF;
    always_ff @(posedge clk) begin
        if (rstb) begin
            wait_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state != WAIT) ? 8'd0 : (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            if (wait_cnt == 8'hFF) timeout_q <= 1'b1;
        end
    end
`endif
endmodule
